// File: rtl/wishbone_ram_arbiter.sv
// wishbone_ram_arbiter: round-robin two-master Wishbone arbiter with per-transfer watchdog
module wishbone_ram_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int SEL_WIDTH  = 4,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  m0_cyc_i,
    input  logic                  m0_stb_i,
    input  logic                  m0_we_i,
    input  logic [ADDR_WIDTH-1:0] m0_addr_i,
    input  logic [DATA_WIDTH-1:0] m0_data_i,
    input  logic [SEL_WIDTH-1:0]  m0_sel_i,
    output logic [DATA_WIDTH-1:0] m0_data_o,
    output logic                  m0_ack_o,
    output logic                  m0_err_o,
    input  logic                  m1_cyc_i,
    input  logic                  m1_stb_i,
    input  logic                  m1_we_i,
    input  logic [ADDR_WIDTH-1:0] m1_addr_i,
    input  logic [DATA_WIDTH-1:0] m1_data_i,
    input  logic [SEL_WIDTH-1:0]  m1_sel_i,
    output logic [DATA_WIDTH-1:0] m1_data_o,
    output logic                  m1_ack_o,
    output logic                  m1_err_o,
    output logic                  s_cyc_o,
    output logic                  s_stb_o,
    output logic                  s_we_o,
    output logic [ADDR_WIDTH-1:0] s_addr_o,
    output logic [DATA_WIDTH-1:0] s_data_o,
    output logic [SEL_WIDTH-1:0]  s_sel_o,
    input  logic [DATA_WIDTH-1:0] s_data_i,
    input  logic                  s_ack_i,
    output logic [1:0]            gnt_o
);
    typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;
    state_t state, nxt;
    logic last, g0, g1, cyc, stb, wd_to;
    logic [7:0] wd_cnt;
    assign g0 = state == GNT0;
    assign g1 = state == GNT1;
    assign gnt_o = {g1, g0};
    assign cyc = g0 ? m0_cyc_i : g1 ? m1_cyc_i : 1'b0;
    assign stb = g0 ? m0_stb_i : g1 ? m1_stb_i : 1'b0;
    assign wd_to = wd_cnt == 8'(TIMEOUT);
    // Holding cyc keeps the grant; on release the other requester takes over without an IDLE bubble.
    always_comb begin
        nxt = (g0 && m0_cyc_i) ? GNT0 :
              (g1 && m1_cyc_i) ? GNT1 :
              (m0_cyc_i && m1_cyc_i) ? (last ? GNT0 : GNT1) :
              m0_cyc_i ? GNT0 :
              m1_cyc_i ? GNT1 : IDLE;
    end
    assign s_cyc_o  = cyc & ~wd_to;
    assign s_stb_o  = stb & ~wd_to;
    assign s_we_o   = g0 ? m0_we_i : g1 ? m1_we_i : 1'b0;
    assign s_addr_o = g0 ? m0_addr_i : g1 ? m1_addr_i : '0;
    assign s_data_o = g0 ? m0_data_i : g1 ? m1_data_i : '0;
    assign s_sel_o  = g0 ? m0_sel_i : g1 ? m1_sel_i : '0;
    assign m0_data_o = s_data_i;
    assign m1_data_o = s_data_i;
    assign m0_ack_o = g0 & s_ack_i;
    assign m1_ack_o = g1 & s_ack_i;
    assign m0_err_o = g0 & wd_to & ~s_ack_i;
    assign m1_err_o = g1 & wd_to & ~s_ack_i;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            last   <= 1'b1;
            wd_cnt <= '0;
        end else begin
            state  <= nxt;
            last   <= (nxt == GNT0) ? 1'b0 : (nxt == GNT1) ? 1'b1 : last;
            wd_cnt <= (nxt != state || !(cyc && stb) || s_ack_i || wd_to) ? 8'd0 : wd_cnt + 8'd1;
        end
    end
endmodule

// File: tb/tb_wishbone_ram_arbiter.sv
// tb_wishbone_ram_arbiter: directed self-checking bench for wishbone_ram_arbiter
module tb_wishbone_ram_arbiter;
    logic clk = 1'b0, rst = 1'b1;
    logic m0_cyc = 0, m0_stb = 0, m0_we = 0, m1_cyc = 0, m1_stb = 0, m1_we = 0;
    logic [31:0] m0_addr = 0, m0_wdat = 0, m1_addr = 0, m1_wdat = 0;
    logic [3:0] m0_sel = 0, m1_sel = 0;
    logic [31:0] m0_rdat, m1_rdat, s_addr, s_wdat, s_rdat = 0;
    logic m0_ack, m0_err, m1_ack, m1_err, s_cyc, s_stb, s_we, s_ack = 0;
    logic [3:0] s_sel;
    logic [1:0] gnt;
    int tests = 0, fails = 0;

    wishbone_ram_arbiter #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_addr_i(m0_addr),
        .m0_data_i(m0_wdat), .m0_sel_i(m0_sel), .m0_data_o(m0_rdat), .m0_ack_o(m0_ack), .m0_err_o(m0_err),
        .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_addr_i(m1_addr),
        .m1_data_i(m1_wdat), .m1_sel_i(m1_sel), .m1_data_o(m1_rdat), .m1_ack_o(m1_ack), .m1_err_o(m1_err),
        .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_addr_o(s_addr), .s_data_o(s_wdat),
        .s_sel_o(s_sel), .s_data_i(s_rdat), .s_ack_i(s_ack), .gnt_o(gnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // inputs change 1ns after the edge, checks run 2ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        // reset state
        s_rdat = 32'hA5A5_0001;
        #3;
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_scyc", 32'(s_cyc), 0);
        chk("rst_ack", 32'({m0_ack, m0_err, m1_ack, m1_err}), 0);
        chk("rst_data", m1_rdat, 32'hA5A5_0001);
        tick();
        rst = 0;
        tick();

        // single read by m0
        m0_cyc = 1; m0_stb = 1; m0_addr = 32'h100;
        settle();
        chk("rd_idle_gnt", 32'(gnt), 0);
        tick();
        settle();
        chk("rd_gnt", 32'(gnt), 32'b01);
        chk("rd_scyc", 32'({s_cyc, s_stb, s_we}), 32'b110);
        chk("rd_addr", s_addr, 32'h100);
        chk("rd_noack", 32'(m0_ack), 0);
        tick();
        s_ack = 1; s_rdat = 32'hDEADBEEF;
        settle();
        chk("rd_ack", 32'({m0_ack, m1_ack}), 32'b10);
        chk("rd_data", m0_rdat, 32'hDEADBEEF);
        tick();
        s_ack = 0; m0_cyc = 0; m0_stb = 0;
        settle();
        chk("rd_ack_low", 32'(m0_ack), 0);
        tick();
        settle();
        chk("rd_back_idle", 32'(gnt), 0);

        // simultaneous first request after reset: m0 wins although m0 was last
        rst = 1;
        tick();
        rst = 0;
        m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
        tick();
        settle();
        chk("sim_first", 32'(gnt), 32'b01);
        tick();
        s_ack = 1;
        settle();
        chk("sim_ack", 32'({m0_ack, m1_ack}), 32'b10);
        tick();
        s_ack = 0; m0_cyc = 0; m0_stb = 0;
        settle();
        chk("sim_gap_scyc", 32'(s_cyc), 0);
        chk("sim_gap_gnt", 32'(gnt), 32'b01);
        tick();
        settle();
        chk("sim_second", 32'(gnt), 32'b10);
        chk("sim_second_scyc", 32'(s_cyc), 1);
        s_ack = 1;
        settle();
        chk("sim_m1_ack", 32'({m0_ack, m1_ack}), 32'b01);
        tick();
        s_ack = 0; m1_cyc = 0; m1_stb = 0;
        tick();

        // round-robin with both masters re-requesting immediately
        m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
        tick();
        for (int i = 0; i < 6; i++) begin
            s_ack = 1;
            settle();
            chk($sformatf("rr_gnt%0d", i), 32'(gnt), (i % 2 == 0) ? 32'b01 : 32'b10);
            chk($sformatf("rr_ack%0d", i), 32'({m1_ack, m0_ack}), (i % 2 == 0) ? 32'b01 : 32'b10);
            tick();
            s_ack = 0;
            if (i % 2 == 0) begin m0_cyc = 0; m0_stb = 0; end
            else begin m1_cyc = 0; m1_stb = 0; end
            settle();
            chk($sformatf("rr_gap%0d", i), 32'(s_cyc), 0);
            tick();
            m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
        end
        m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
        tick();
        tick();

        // write routing from m1
        m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_addr = 32'h40; m1_wdat = 32'h12345678; m1_sel = 4'b0011;
        m0_addr = 32'hFFFF_0000; m0_wdat = 32'h0BAD_0BAD; m0_sel = 4'b1100;
        tick();
        settle();
        chk("wr_gnt", 32'(gnt), 32'b10);
        chk("wr_we", 32'(s_we), 1);
        chk("wr_addr", s_addr, 32'h40);
        chk("wr_data", s_wdat, 32'h12345678);
        chk("wr_sel", 32'(s_sel), 32'b0011);
        tick();
        s_ack = 1;
        settle();
        chk("wr_ack", 32'({m0_ack, m1_ack}), 32'b01);
        tick();
        s_ack = 0; m1_cyc = 0; m1_stb = 0; m1_we = 0;
        tick();

        // watchdog: error in the 5th granted cycle with TIMEOUT=4
        m0_cyc = 1; m0_stb = 1;
        tick();
        for (int k = 0; k < 4; k++) begin
            settle();
            chk($sformatf("wd_pre%0d", k), 32'({m0_err, m0_ack, s_stb}), 32'b001);
            tick();
        end
        settle();
        chk("wd_err", 32'({m0_err, m0_ack, m1_err}), 32'b100);
        chk("wd_drop", 32'({s_cyc, s_stb}), 0);
        tick();
        settle();
        chk("wd_after", 32'({m0_err, s_cyc, s_stb}), 32'b011);
        for (int k = 0; k < 3; k++) tick();
        settle();
        chk("wd_pre_race", 32'(m0_err), 0);
        tick();
        s_ack = 1;
        settle();
        chk("wd_race", 32'({m0_ack, m0_err}), 32'b10);
        tick();
        s_ack = 0;
        settle();
        chk("wd_race_after", 32'({m0_ack, m0_err}), 0);
        m0_cyc = 0; m0_stb = 0;
        tick();
        tick();

        // asynchronous reset in GNT1
        m1_cyc = 1; m1_stb = 1;
        tick();
        settle();
        chk("rs_gnt", 32'(gnt), 32'b10);
        m0_cyc = 1; m0_stb = 1; s_ack = 1;
        #1 rst = 1;
        #1;
        chk("rs_drop", 32'({s_cyc, s_stb, s_we}), 0);
        chk("rs_gnt_idle", 32'(gnt), 0);
        chk("rs_noack", 32'({m1_ack, m1_err}), 0);
        s_ack = 0;
        tick();
        rst = 0;
        tick();
        settle();
        chk("rs_m0_first", 32'(gnt), 32'b01);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/wishbone_ram_arbiter.md
# wishbone_ram_arbiter

Two-master Wishbone arbiter that shares the single synchronous RAM bridge between the data-side master (m0) and the instruction-side master (m1) of the OpenMIPS core. It grants the slave port to one master per bus cycle (`cyc` held), using round-robin on contention, and routes that master's request and response signals. It also runs a per-transfer watchdog that terminates a stalled transfer with a one-cycle error.

## Interface

**Parameters**
- `ADDR_WIDTH`, 32, address width.
- `DATA_WIDTH`, 32, data width.
- `SEL_WIDTH`, 4, byte-select width.
- `TIMEOUT`, 15, cycles of unacknowledged `cyc&stb` before an error is forced. Legal range 2..255.

**Ports**
- `clk` in 1: single clock; everything is posedge.
- `rst` in 1: asynchronous, active-high reset.
- `m0_cyc_i`, `m0_stb_i`, `m0_we_i` in 1 each: master 0 (data bus) request.
- `m0_addr_i` in ADDR_WIDTH; `m0_data_i` in DATA_WIDTH; `m0_sel_i` in SEL_WIDTH.
- `m0_data_o` out DATA_WIDTH: read data. Always equals `s_data_i`.
- `m0_ack_o`, `m0_err_o` out 1 each: transfer termination for master 0.
- `m1_*`: identical set for master 1 (instruction bus).
- `s_cyc_o`, `s_stb_o`, `s_we_o` out 1 each: to the RAM bridge.
- `s_addr_o` out ADDR_WIDTH; `s_data_o` out DATA_WIDTH; `s_sel_o` out SEL_WIDTH.
- `s_data_i` in DATA_WIDTH; `s_ack_i` in 1: response from the RAM bridge.
- `gnt_o` out 2: one-hot current grant (`[0]` = m0, `[1]` = m1); `2'b00` in IDLE.

## Operation

**State machine**
- States: IDLE, GNT0, GNT1.
- `last` register (1 bit) records the master most recently granted.

**IDLE transitions**
- Only `m0_cyc_i` high → GNT0.
- Only `m1_cyc_i` high → GNT1.
- Both high → grant the master that is not `last`.
- Neither high → stay in IDLE.

**GNTx transitions**
- Stay in GNTx while `mx_cyc_i` is high. The grant is never preempted.
- When `mx_cyc_i` goes low:
  - the other master's `cyc` is high → move directly to that master's grant (no IDLE bubble);
  - otherwise → IDLE.
- `last` updates to x on entry to GNTx.

**Routing**
- In GNTx, the `s_*` outputs are combinational copies of the `mx_*` inputs.
- `mx_ack_o = s_ack_i`.
- The non-granted master's `ack` and `err` are 0.
- In IDLE, all `s_*` outputs and `gnt_o` are 0.

**Watchdog**
- The 8-bit counter `wd_cnt` increments in each GNTx cycle where `mx_cyc_i & mx_stb_i & ~s_ack_i`.
- It clears to 0 on `s_ack_i`, on any state change, or when `stb` is low.
- When `wd_cnt == TIMEOUT`:
  - `mx_err_o = 1` for that cycle;
  - `s_cyc_o` and `s_stb_o` are forced to 0 for that cycle, so the bridge drops the access;
  - the counter clears at the next edge.
- `err` and `ack` are never both high. If `s_ack_i` arrives in the same cycle as the timeout, `ack` wins and `err` is suppressed.

**Reset**
- State = IDLE, `last` = 1 (so m0 wins the first contention), `wd_cnt` = 0.
- All outputs are 0 except `m*_data_o`, which follows `s_data_i`.
- Assertion mid-transfer aborts the transfer immediately (asynchronous). No `ack` or `err` is generated.

## Timing

- Arbitration latency is 1 cycle. `cyc` rising in IDLE at edge N means `gnt_o` and `s_cyc_o` are valid after edge N+1.
- With the bridge in combinational mode (ack one cycle after `stb`), a single access takes 3 cycles from the master's `cyc` rising to the `ack` cycle:
  - IDLE;
  - request;
  - ack.
- Back-to-back handoff: master x drops `cyc` in cycle K, and the other master is granted from cycle K+1.
  - `s_cyc_o` is low in cycle K, which gives the bridge phase counter a clean boundary.
- A held `cyc` with multiple `stb` pulses stays on one grant. Each access is acked by the bridge.
- The error fires exactly TIMEOUT+1 cycles after `stb` rises without an ack.
- `s_data_i` passes straight through to the `m*_data_o` outputs, with no register.

## Test plan

- **Single read, m0.** m0 `cyc`/`stb` with addr `0x100`, bridge returns `0xDEADBEEF` one cycle later → `gnt_o=01`, `m0_ack_o` pulses once, `m0_data_o=0xDEADBEEF`, `m1_ack_o=0` throughout.
- **Simultaneous first request.** m0 and m1 raise `cyc` in the same cycle after reset → m0 is granted first (`last=1`). When m0 drops `cyc`, m1 is granted on the next cycle with `s_cyc_o` low for exactly one cycle.
- **Round-robin fairness.** Both masters keep re-requesting immediately for 6 transfers → grant order is 0, 1, 0, 1, 0, 1 and no master gets two consecutive grants.
- **Write routing.** m1 writes `0x12345678`, sel `4'b0011`, addr `0x40` → `s_we_o=1`, `s_data_o`, `s_sel_o` and `s_addr_o` match m1's inputs, and `m1_ack_o` pulses.
- **Watchdog.** Bridge `ack` held low with `TIMEOUT=4` and m0 `stb` high → `m0_err_o` pulses in the 5th cycle after `stb`, with `s_cyc_o` and `s_stb_o` low in that cycle and `m0_ack_o` never high. Then, with `s_ack_i` arriving in exactly the cycle `wd_cnt==TIMEOUT`, only `m0_ack_o` rises.
- **Reset mid-transfer.** `rst` is pulsed while in GNT1 with `stb` high → all `s_*` outputs drop asynchronously and the state is IDLE. After release with both masters requesting, m0 is granted first.
